// File: rtl/fmap_pkg.sv
// Shared types and constants for the feature-map read sequencer.
package fmap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fmap_state_e;

    localparam int P2_ROWS = 4;
    localparam int P2_COLS = 4;
    localparam int P2_CH   = 12;

    // A count of 1 still needs a 1-bit index.
    function automatic int clog2m1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fmap_read_seq_if.sv
// Handshake/bus bundle between the read sequencer and its memory/consumer.
// Optional row/col coordinate outputs exist only when FMAP_RD_COORD_EN is defined.
interface fmap_read_seq_if #(
    parameter int PIX_W = 4,
    parameter int CH_W  = 4
`ifdef FMAP_RD_COORD_EN
    ,
    parameter int ROW_W = 2,
    parameter int COL_W = 2
`endif
);
    logic             start;
    logic             ready;
    logic             rd_en;
    logic [PIX_W-1:0] pix_addr;
    logic [CH_W-1:0]  ch;
    logic             data_valid;
    logic             data_last;
    logic             busy;
    logic             done;
`ifdef FMAP_RD_COORD_EN
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
`endif

    modport master (
`ifdef FMAP_RD_COORD_EN
        output row, col,
`endif
        input  start, ready,
        output rd_en, pix_addr, ch, data_valid, data_last, busy, done
    );

    modport slave (
`ifdef FMAP_RD_COORD_EN
        input  row, col,
`endif
        output start, ready,
        input  rd_en, pix_addr, ch, data_valid, data_last, busy, done
    );

endinterface

// File: rtl/fmap_valid_pipe.sv
// MEM_LAT-deep {valid,last} delay line that lines the strobes up with memory data.
module fmap_valid_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_vld,
    input  logic i_last,
    output logic o_vld,
    output logic o_last
);
    logic [LAT-1:0][1:0] r_stage;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= {i_vld, i_last};
            for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign {o_vld, o_last} = r_stage[LAT-1];

endmodule

// File: rtl/fmap_read_seq.sv
// Feature-map read sequencer: walks ROWS*COLS pixels per channel for CHANNELS channels.
// Define FMAP_RD_COORD_EN to also emit row/col coordinates.
module fmap_read_seq
    import fmap_pkg::*;
#(
    parameter int ROWS     = P2_ROWS,
    parameter int COLS     = P2_COLS,
    parameter int CHANNELS = P2_CH,
    parameter int MEM_LAT  = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    fmap_read_seq_if.master bus
);
    localparam int NPIX  = ROWS * COLS;
    localparam int PIX_W = clog2m1(NPIX);
    localparam int CH_W  = clog2m1(CHANNELS);
    localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(NPIX - 1);
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CHANNELS - 1);
`ifdef FMAP_RD_COORD_EN
    localparam int ROW_W = clog2m1(ROWS);
    localparam int COL_W = clog2m1(COLS);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
`endif

    fmap_state_e      r_state;
    logic [PIX_W-1:0] r_pix;
    logic [CH_W-1:0]  r_ch;
    logic             w_rd;
    logic             w_pix_wrap;
    logic             w_last;
    logic             w_dv;
    logic             w_dl;
    logic             w_done;

    assign w_rd       = (r_state == RUN) & bus.ready;
    assign w_pix_wrap = (r_pix == PIX_MAX);
    assign w_last     = w_pix_wrap & (r_ch == CH_MAX);
    assign w_done     = w_dv & w_dl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_pix   <= '0;
            r_ch    <= '0;
`ifdef FMAP_RD_COORD_EN
            r_row   <= '0;
            r_col   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_pix   <= '0;
                        r_ch    <= '0;
`ifdef FMAP_RD_COORD_EN
                        r_row   <= '0;
                        r_col   <= '0;
`endif
                    end
                end
                RUN: begin
                    // The final issue leaves every counter on its last value.
                    if (w_rd && w_last) begin
                        r_state <= DRAIN;
                    end else if (w_rd) begin
                        if (w_pix_wrap) begin
                            r_pix <= '0;
                            r_ch  <= r_ch + 1'b1;
                        end else begin
                            r_pix <= r_pix + 1'b1;
                        end
`ifdef FMAP_RD_COORD_EN
                        if (r_col == COL_MAX) begin
                            r_col <= '0;
                            r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
`endif
                    end
                end
                DRAIN: begin
                    if (w_done) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fmap_valid_pipe #(.LAT(MEM_LAT)) u_vpipe (
        .clk    (clk),
        .reset_n(reset_n),
        .i_vld  (w_rd),
        .i_last (w_rd & w_last),
        .o_vld  (w_dv),
        .o_last (w_dl)
    );

    assign bus.rd_en      = w_rd;
    assign bus.pix_addr   = r_pix;
    assign bus.ch         = r_ch;
    assign bus.data_valid = w_dv;
    assign bus.data_last  = w_dl;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = w_done;
`ifdef FMAP_RD_COORD_EN
    assign bus.row        = r_row;
    assign bus.col        = r_col;
`endif

endmodule

// File: tb/tb_fmap_read_seq.sv
// Randomized self-checking bench: a default-geometry DUT and a 3x5x2, latency-3 DUT
// share stimulus and are each compared every cycle against a count-based reference.
module tb_fmap_read_seq;
    import fmap_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic ready;
    always #5 clk = ~clk;

    fmap_read_seq_if #(.PIX_W(clog2m1(16)), .CH_W(clog2m1(12))
`ifdef FMAP_RD_COORD_EN
        , .ROW_W(clog2m1(4)), .COL_W(clog2m1(4))
`endif
    ) bus_a ();
    fmap_read_seq_if #(.PIX_W(clog2m1(15)), .CH_W(clog2m1(2))
`ifdef FMAP_RD_COORD_EN
        , .ROW_W(clog2m1(3)), .COL_W(clog2m1(5))
`endif
    ) bus_b ();

    assign bus_a.start = start;
    assign bus_a.ready = ready;
    assign bus_b.start = start;
    assign bus_b.ready = ready;

    fmap_read_seq #(.ROWS(4), .COLS(4), .CHANNELS(12), .MEM_LAT(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a.master));
    fmap_read_seq #(.ROWS(3), .COLS(5), .CHANNELS(2), .MEM_LAT(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b.master));

    typedef struct {
        logic rd, dv, dl, busy, done;
        int   pix, ch, row, col;
    } obs_t;

    int n_chk = 0;
    int n_err = 0;
    int cyc_no = 0;

    // reference state per DUT: phase 0 idle / 1 issuing / 2 waiting for returns
    int       ph  [2];
    int       iss [2];
    logic [7:0] hv [2];
    logic [7:0] hl [2];
    logic     e_rd [2];
    logic     e_done [2];
    int       n_rd [2];
    int       first_rd [2];
    int       last_rd [2];

    function automatic int f_cols(int d); return d ? 5 : 4;   endfunction
    function automatic int f_npix(int d); return d ? 15 : 16; endfunction
    function automatic int f_n(int d);    return d ? 30 : 192; endfunction
    function automatic int f_lat(int d);  return d ? 3 : 1;   endfunction

    function automatic obs_t obs(int d);
        obs_t o;
        o.row = 0;
        o.col = 0;
        if (d == 0) begin
            o.rd = bus_a.rd_en; o.dv = bus_a.data_valid; o.dl = bus_a.data_last;
            o.busy = bus_a.busy; o.done = bus_a.done;
            o.pix = int'(bus_a.pix_addr); o.ch = int'(bus_a.ch);
`ifdef FMAP_RD_COORD_EN
            o.row = int'(bus_a.row); o.col = int'(bus_a.col);
`endif
        end else begin
            o.rd = bus_b.rd_en; o.dv = bus_b.data_valid; o.dl = bus_b.data_last;
            o.busy = bus_b.busy; o.done = bus_b.done;
            o.pix = int'(bus_b.pix_addr); o.ch = int'(bus_b.ch);
`ifdef FMAP_RD_COORD_EN
            o.row = int'(bus_b.row); o.col = int'(bus_b.col);
`endif
        end
        return o;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc_no, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; iss[d] = 0; hv[d] = '0; hl[d] = '0;
        end
    endtask

    task automatic eval_all();
        for (int d = 0; d < 2; d++) begin
            obs_t o;
            logic edv, edl;
            string s;
            o   = obs(d);
            s   = d ? "B" : "A";
            edv = hv[d][f_lat(d)-1];
            edl = hl[d][f_lat(d)-1];
            e_rd[d]   = (ph[d] == 1) && ready;
            e_done[d] = edv && edl;
            chk({s, ".rd_en"},      o.rd,   e_rd[d]);
            chk({s, ".data_valid"}, o.dv,   edv);
            chk({s, ".data_last"},  o.dl,   edl);
            chk({s, ".done"},       o.done, e_done[d]);
            chk({s, ".busy"},       o.busy, ph[d] != 0);
            if (ph[d] == 1) begin
                chk({s, ".pix_addr"}, o.pix, iss[d] % f_npix(d));
                chk({s, ".ch"},       o.ch,  iss[d] / f_npix(d));
`ifdef FMAP_RD_COORD_EN
                chk({s, ".row"}, o.row, (iss[d] % f_npix(d)) / f_cols(d));
                chk({s, ".col"}, o.col, (iss[d] % f_npix(d)) % f_cols(d));
`endif
            end
`ifdef FMAP_RD_COORD_EN
            chk({s, ".pix_eq_rc"}, o.pix, o.row * f_cols(d) + o.col);
`endif
            if (o.rd === 1'b1) begin
                n_rd[d]++;
                if (first_rd[d] < 0) first_rd[d] = cyc_no;
                last_rd[d] = cyc_no;
            end
        end
    endtask

    task automatic update_all();
        for (int d = 0; d < 2; d++) begin
            hv[d] = {hv[d][6:0], e_rd[d]};
            hl[d] = {hl[d][6:0], e_rd[d] && (iss[d] == f_n(d) - 1)};
            case (ph[d])
                0: if (start) begin ph[d] = 1; iss[d] = 0; end
                1: if (e_rd[d]) begin
                       iss[d]++;
                       if (iss[d] == f_n(d)) ph[d] = 2;
                   end
                default: if (e_done[d]) ph[d] = 0;
            endcase
        end
    endtask

    // called at a negedge with inputs already applied
    task automatic cyc();
        #1;
        eval_all();
        @(posedge clk);
        update_all();
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic clr_stats();
        for (int d = 0; d < 2; d++) begin
            n_rd[d] = 0; first_rd[d] = -1; last_rd[d] = -1;
        end
    endtask

    // mode 0: ready high, 1: alternate 1,0, 2: random
    task automatic run_idle(input int mode, input int maxc);
        int c = 0;
        start = 1'b0;
        while ((ph[0] != 0 || ph[1] != 0) && c < maxc) begin
            ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~ready : 1'($urandom);
            cyc();
            c++;
        end
        chk("run_idle_bound", int'(c < maxc), 1);
    endtask

    task automatic zero_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            obs_t o;
            o = obs(d);
            chk({tag, ".rd_en"}, o.rd, 0);
            chk({tag, ".dv"},    o.dv, 0);
            chk({tag, ".done"},  o.done, 0);
            chk({tag, ".busy"},  o.busy, 0);
            chk({tag, ".pix"},   o.pix, 0);
            chk({tag, ".ch"},    o.ch, 0);
        end
    endtask

    initial begin
        int c;
        start = 1'b0;
        ready = 1'b0;
        reset_n = 1'b0;
        model_clear();
        clr_stats();
        @(negedge clk);
        #1;
        zero_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // ready held high: back-to-back issue
        clr_stats();
        start = 1'b1; ready = 1'b1;
        cyc();
        run_idle(0, 400);
        chk("A.reads_ready1", n_rd[0], 192);
        chk("A.span_ready1",  last_rd[0] - first_rd[0] + 1, 192);
        chk("B.reads_ready1", n_rd[1], 30);
        cyc();

        // ready alternating
        clr_stats();
        start = 1'b1; ready = 1'b0;
        cyc();
        run_idle(1, 800);
        chk("A.reads_toggle", n_rd[0], 192);
        chk("A.span_toggle",  last_rd[0] - first_rd[0] + 1, 383);
        chk("B.span_toggle",  last_rd[1] - first_rd[1] + 1, 59);

        // random starts during RUN, then start held across done into a restart
        start = 1'b1;
        cyc();
        c = 0;
        while (iss[0] < 150 && c < 2000) begin
            start = 1'($urandom);
            ready = 1'($urandom);
            cyc();
            c++;
        end
        chk("A.mid_bound", int'(c < 2000), 1);
        start = 1'b1;
        c = 0;
        while (ph[0] != 0 && c < 2000) begin
            ready = 1'($urandom);
            cyc();
            c++;
        end
        chk("A.held_done_bound", int'(c < 2000), 1);
        cyc();
        chk("A.held_restart", ph[0], 1);
        run_idle(2, 3000);

        // reset mid-sequence at read 100
        start = 1'b1; ready = 1'b1;
        cyc();
        start = 1'b0;
        c = 0;
        while (iss[0] < 100 && c < 300) begin
            cyc();
            c++;
        end
        chk("A.reach100", iss[0], 100);
        reset_n = 1'b0;
        #1;
        zero_outputs("midreset");
        model_clear();
        @(negedge clk);
        cyc();
        reset_n = 1'b1;
        cyc();
        clr_stats();
        start = 1'b1;
        cyc();
        run_idle(2, 2000);
        chk("A.reads_after_reset", n_rd[0], 192);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
